// File: rtl/aes_128_sched_pkg.sv
// Shared widths and types for the aes_128 core scheduler.
package aes_128_sched_pkg;

    localparam int BLOCK_W  = 128;
    localparam int KEY_W    = 128;
    localparam int MAX_ID_W = 4;

    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Tag carried alongside each block while it is inside the core.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/aes_128_scheduler_if.sv
// Request, core and response signals of the aes_128 scheduler.
interface aes_128_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = aes_128_sched_pkg::id_width(NUM_REQ)
);
    import aes_128_sched_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*BLOCK_W-1:0] req_state;
    logic [NUM_REQ*KEY_W-1:0]   req_key;
    logic [BLOCK_W-1:0]         core_state;
    logic [KEY_W-1:0]           core_key;
    logic [BLOCK_W-1:0]         core_out;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [BLOCK_W-1:0]         rsp_data;
    logic [ID_W-1:0]            rsp_id;
    logic                       busy;

    modport slave (
        input  req_valid, req_state, req_key, core_out, rsp_ready,
        output req_ready, core_state, core_key, rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req_valid, req_state, req_key, core_out, rsp_ready,
        input  req_ready, core_state, core_key, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/aes_128_rsp_fifo.sv
// First-word fall-through FIFO holding completed ciphertexts and their tags.
module aes_128_rsp_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Head is masked while empty so stale storage never leaks to the outputs.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/aes_128_scheduler.sv
// Round-robin sharing of one non-stallable pipelined aes_128 core between requesters,
// with credit-limited issue so the response FIFO can never overflow.
module aes_128_scheduler
    import aes_128_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 32,
    parameter int ID_W       = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    aes_128_scheduler_if.slave bus
);

    localparam int OUT_W = $clog2(FIFO_DEPTH + 1);

    logic [BLOCK_W-1:0]      state_arr [NUM_REQ];
    logic [KEY_W-1:0]        key_arr   [NUM_REQ];
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         scan;
    logic [ID_W-1:0]         cand_idx;
    logic                    cand_found;
    logic                    credit_ok;
    logic                    accept;
    logic                    pop;
    logic [OUT_W-1:0]        outstanding_q, outstanding_d;
    logic [BLOCK_W-1:0]      core_state_q;
    logic [KEY_W-1:0]        core_key_q;
    tag_t                    tag_d;
    tag_t                    tag_q [LATENCY+1];
    logic [BLOCK_W+ID_W-1:0] fifo_rdata;
    logic [OUT_W-1:0]        fifo_count;
    logic                    fifo_full, fifo_empty;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign state_arr[g] = bus.req_state[BLOCK_W*g +: BLOCK_W];
        assign key_arr[g]   = bus.req_key[KEY_W*g +: KEY_W];
    end

    // Outstanding covers both blocks inside the core and entries waiting in the FIFO.
    assign credit_ok = (outstanding_q < OUT_W'(FIFO_DEPTH));
    assign accept    = cand_found && credit_ok && !rst;
    assign pop       = bus.rsp_ready && !fifo_empty;

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!cand_found && bus.req_valid[scan]) begin
                cand_found = 1'b1;
                cand_idx   = scan;
            end
        end
    end

    always_comb begin
        bus.req_ready = accept ? (NUM_REQ'(1) << cand_idx) : '0;
        ptr_d         = ptr_q;
        if (accept) begin
            ptr_d = (cand_idx == ID_W'(NUM_REQ - 1)) ? '0 : cand_idx + 1'b1;
        end
        tag_d.valid = accept;
        tag_d.id    = MAX_ID_W'(cand_idx);
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= '0;
            outstanding_q <= '0;
            core_state_q  <= '0;
            core_key_q    <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            outstanding_q <= outstanding_d;
            core_state_q  <= accept ? state_arr[cand_idx] : '0;
            core_key_q    <= accept ? key_arr[cand_idx] : '0;
            tag_q[0]      <= tag_d;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    aes_128_rsp_fifo #(
        .WIDTH (BLOCK_W + ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (tag_q[LATENCY].valid),
        .wdata_i ({bus.core_out, tag_q[LATENCY].id[ID_W-1:0]}),
        .pop_i   (bus.rsp_ready),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.core_state = core_state_q;
    assign bus.core_key   = core_key_q;
    assign bus.rsp_valid  = !fifo_empty;
    assign bus.rsp_data   = fifo_rdata[ID_W +: BLOCK_W];
    assign bus.rsp_id     = fifo_rdata[ID_W-1:0];
    assign bus.busy       = (outstanding_q != '0);

    // Credit accounting makes a push into a full FIFO unreachable.
    assert property (@(posedge clk) disable iff (rst) !(tag_q[LATENCY].valid && fifo_full));
    assert property (@(posedge clk) disable iff (rst) fifo_count <= outstanding_q);

endmodule

// File: tb/tb_aes_128_scheduler.sv
// Directed bench for aes_128_scheduler with a behavioural delay-line stand-in for the core.
module tb_aes_128_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int LATENCY    = 21;
    localparam int FIFO_DEPTH = 32;
    localparam int ID_W       = 2;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [127:0]    data;
    } item_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    tests = 0;
    int    fails = 0;
    item_t acc_q[$];
    item_t pop_q[$];
    logic [127:0] core_pipe [LATENCY];

    aes_128_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    aes_128_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in core: known FIPS-197 vector, otherwise a cheap keyed mix.
    function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
        if (s == C1_PT && k == C1_KEY) return C1_CT;
        return s ^ {k[63:0], k[127:64]};
    endfunction

    function automatic logic [127:0] st_of(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h1111_1111 * 32'(i + 1), 64'h0123_4567_89AB_CDEF};
    endfunction

    function automatic logic [127:0] key_of(input int i);
        return {4{32'hA5A5_0000 + 32'(i)}};
    endfunction

    always @(posedge clk) begin
        core_pipe[0] <= core_fn(bus.core_state, bus.core_key);
        for (int k = 1; k < LATENCY; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign bus.core_out = core_pipe[LATENCY-1];

    always @(negedge clk) begin
        item_t it;
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    it.id   = ID_W'(i);
                    it.data = core_fn(bus.req_state[128*i +: 128], bus.req_key[128*i +: 128]);
                    acc_q.push_back(it);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                it.id   = bus.rsp_id;
                it.data = bus.rsp_data;
                pop_q.push_back(it);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [127:0] s, input logic [127:0] k);
        bus.req_state[128*i +: 128] = s;
        bus.req_key[128*i +: 128]   = k;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        acc_q.delete();
        pop_q.delete();
    endtask

    task automatic wait_pops(input int n, input int budget);
        int c = 0;
        while (pop_q.size() < n && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_state = '0;
        bus.req_key   = '0;
        #1 rst = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        tests++; if (bus.req_ready !== 4'h0) begin fails++; $display("FAIL reset_req_ready: got %h expected 0", bus.req_ready); end
        tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.core_state !== 128'h0) begin fails++; $display("FAIL reset_core_state: got %h expected 0", bus.core_state); end
        tests++; if (bus.core_key !== 128'h0) begin fails++; $display("FAIL reset_core_key: got %h expected 0", bus.core_key); end
        tests++; if (bus.rsp_data !== 128'h0) begin fails++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
        tests++; if (bus.rsp_id !== 2'h0) begin fails++; $display("FAIL reset_rsp_id: got %h expected 0", bus.rsp_id); end
        step();
        step();
        bus.req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_fips();
        int n = 0;
        bit seen = 0;
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(2, C1_PT, C1_KEY);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL fips_req_ready: got %b expected 0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        @(negedge clk);
        tests++; if (bus.core_state !== C1_PT) begin fails++; $display("FAIL fips_core_state: got %h expected %h", bus.core_state, C1_PT); end
        tests++; if (bus.core_key !== C1_KEY) begin fails++; $display("FAIL fips_core_key: got %h expected %h", bus.core_key, C1_KEY); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL fips_busy: got %b expected 1", bus.busy); end
        while (!seen && n < 40) begin
            step();
            n++;
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        tests++; if (!seen || n != LATENCY + 1) begin fails++; $display("FAIL fips_latency: got %0d edges (seen=%0d) expected %0d", n, seen, LATENCY + 1); end
        tests++; if (bus.rsp_data !== C1_CT) begin fails++; $display("FAIL fips_rsp_data: got %h expected %h", bus.rsp_data, C1_CT); end
        tests++; if (bus.rsp_id !== 2'd2) begin fails++; $display("FAIL fips_rsp_id: got %0d expected 2", bus.rsp_id); end
        step();
        @(negedge clk);
        tests++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL fips_idle: got valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, st_of(i), key_of(i));
        bus.req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            exp = 4'b0001 << (c % 4);
            @(negedge clk);
            tests++; if (bus.req_ready !== exp) begin fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, bus.req_ready, exp); end
            step();
        end
        bus.req_valid = '0;
        wait_pops(8, 60);
        tests++; if (pop_q.size() != 8) begin fails++; $display("FAIL rr_count: got %0d expected 8", pop_q.size()); end
        for (int k = 0; k < pop_q.size() && k < 8; k++) begin
            tests++; if (pop_q[k].id !== ID_W'(k % 4) || pop_q[k].data !== core_fn(st_of(k % 4), key_of(k % 4))) begin
                fails++; $display("FAIL rr_rsp[%0d]: got id=%0d data=%h expected id=%0d", k, pop_q[k].id, pop_q[k].data, k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, st_of(i), key_of(i));
        bus.req_valid = 4'hF;
        repeat (60) step();
        @(negedge clk);
        tests++; if (acc_q.size() != FIFO_DEPTH) begin fails++; $display("FAIL bp_accepts: got %0d expected %0d", acc_q.size(), FIFO_DEPTH); end
        tests++; if (bus.req_ready !== 4'h0) begin fails++; $display("FAIL bp_ready_low: got %b expected 0000", bus.req_ready); end
        tests++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL bp_holding: got valid=%b busy=%b expected 1 1", bus.rsp_valid, bus.busy); end
        step();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus.req_ready !== 4'h0) begin fails++; $display("FAIL bp_ready_before_pop: got %b expected 0000", bus.req_ready); end
        step();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL bp_credit_return: got %b expected 0001", bus.req_ready); end
        step();
        @(negedge clk);
        tests++; if (bus.req_ready !== 4'h0) begin fails++; $display("FAIL bp_single_credit: got %b expected 0000", bus.req_ready); end
        repeat (10) step();
        tests++; if (acc_q.size() != FIFO_DEPTH + 1 || pop_q.size() != 1) begin fails++; $display("FAIL bp_one_for_one: got accepts=%0d pops=%0d expected %0d 1", acc_q.size(), pop_q.size(), FIFO_DEPTH + 1); end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_pops(FIFO_DEPTH + 1, 100);
        tests++; if (pop_q.size() != FIFO_DEPTH + 1) begin fails++; $display("FAIL bp_drain_count: got %0d expected %0d", pop_q.size(), FIFO_DEPTH + 1); end
        for (int k = 0; k < pop_q.size(); k++) begin
            tests++; if (pop_q[k].id !== ID_W'(k % 4) || pop_q[k].data !== core_fn(st_of(k % 4), key_of(k % 4))) begin
                fails++; $display("FAIL bp_rsp[%0d]: got id=%0d data=%h expected id=%0d", k, pop_q[k].id, pop_q[k].data, k % 4);
            end
        end
    endtask

    task automatic test_push_pop();
        int c = 0;
        do_reset();
        bus.req_valid = 4'hF;
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, {32'(cyc), 32'(i), 64'hFACE_0000_0000_0000 + 64'(cyc)}, key_of(i));
            bus.rsp_ready = cyc[0];
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        while (bus.busy && c < 150) begin
            step();
            c++;
        end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL pp_drain: got busy=%b expected 0", bus.busy); end
        tests++; if (acc_q.size() <= FIFO_DEPTH) begin fails++; $display("FAIL pp_throughput: got %0d accepts expected more than %0d", acc_q.size(), FIFO_DEPTH); end
        tests++; if (pop_q.size() != acc_q.size()) begin fails++; $display("FAIL pp_count: got %0d pops expected %0d", pop_q.size(), acc_q.size()); end
        for (int k = 0; k < pop_q.size() && k < acc_q.size(); k++) begin
            tests++; if (pop_q[k].id !== acc_q[k].id || pop_q[k].data !== acc_q[k].data) begin
                fails++; $display("FAIL pp_rsp[%0d]: got id=%0d data=%h expected id=%0d data=%h", k, pop_q[k].id, pop_q[k].data, acc_q[k].id, acc_q[k].data);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int bad = 0;
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, st_of(i), key_of(i));
        bus.req_valid = 4'b0111;
        repeat (3) step();
        bus.req_valid = '0;
        repeat (5) step();
        rst = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'h0) begin
            fails++; $display("FAIL mid_rst_ctrl: got busy=%b valid=%b ready=%b expected 0 0 0000", bus.busy, bus.rsp_valid, bus.req_ready);
        end
        tests++; if (bus.core_state !== 128'h0 || bus.core_key !== 128'h0 || bus.rsp_data !== 128'h0 || bus.rsp_id !== 2'h0) begin
            fails++; $display("FAIL mid_rst_data: got state=%h key=%h data=%h id=%0d expected all 0", bus.core_state, bus.core_key, bus.rsp_data, bus.rsp_id);
        end
        step();
        step();
        bus.req_valid = '0;
        rst = 1'b0;
        acc_q.delete();
        pop_q.delete();
        for (int c = 0; c < LATENCY + 3; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) bad++;
            step();
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL mid_rst_stale: got %0d cycles with rsp_valid expected 0", bad); end
        set_req(3, C1_PT, C1_KEY);
        bus.req_valid = 4'b1000;
        step();
        bus.req_valid = '0;
        wait_pops(1, 40);
        tests++; if (pop_q.size() != 1 || pop_q[0].data !== C1_CT || pop_q[0].id !== 2'd3) begin
            fails++; $display("FAIL mid_rst_recover: got %0d responses expected one with id 3 data %h", pop_q.size(), C1_CT);
        end
    endtask

    task automatic test_sparse();
        logic [3:0] vld [5];
        logic [3:0] grant [5];
        logic [ID_W-1:0] ids [5];
        vld   = '{4'b0010, 4'b1010, 4'b0010, 4'b0011, 4'b0010};
        grant = '{4'b0010, 4'b1000, 4'b0010, 4'b0001, 4'b0010};
        ids   = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd1};
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, st_of(i), key_of(i));
        for (int s = 0; s < 5; s++) begin
            bus.req_valid = vld[s];
            @(negedge clk);
            tests++; if (bus.req_ready !== grant[s]) begin fails++; $display("FAIL sparse_grant[%0d]: got %b expected %b", s, bus.req_ready, grant[s]); end
            step();
        end
        bus.req_valid = '0;
        wait_pops(5, 40);
        tests++; if (pop_q.size() != 5) begin fails++; $display("FAIL sparse_count: got %0d expected 5", pop_q.size()); end
        for (int k = 0; k < pop_q.size() && k < 5; k++) begin
            tests++; if (pop_q[k].id !== ids[k]) begin fails++; $display("FAIL sparse_rsp_id[%0d]: got %0d expected %0d", k, pop_q[k].id, ids[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_reset_midflight();
        test_sparse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
